pipe_control_unit: RTL
======================

PIPE_CONTROL_UNIT -- requirements
Module: pipe_control_unit

Interface
REQ-001 SHALL have parameters (name, default, meaning): ALU_SEL_W, 4, ALU select width (min 4); REG_W, 5, register address width; CNT_W, 16, stall counter width.
REQ-002 SHALL have ports (name direction width meaning): clk in 1 sole clock; rst_n in 1 reset, asynchronous, active-low.
REQ-003 SHALL have: op in 6 opcode; func in 6 R-type function; rs/rt/rd in REG_W each source/dest fields; id_valid in 1 ID stage holds an instruction.
REQ-004 SHALL have: stall_ext in 1 freeze whole pipe; flush in 1 kill ID instruction (branch/jump resolved).
REQ-005 SHALL have: hazard_stall out 1 stall PC/IF-ID; illegal out 1 undecodable ID instruction.
REQ-006 SHALL have per stage S in {ex, mem, wb}: S_valid out 1, S_rfwe out 1, S_mtorf out 1, S_dst out REG_W; ex_alu_sel out ALU_SEL_W, ex_alu_in_sel/ex_branch/ex_jump out 1; mem_dmwe out 1.
REQ-007 SHALL have stall_cnt out CNT_W, total cycles hazard_stall was 1.

Function
REQ-008 SHALL decode op/func combinationally, with no X on any decoded bit:
- 000000 R-type: rfwe=1, dst=rd, alu_in_sel=0; func 100000 add sel 2, 100010 sub 3, 100100 and 0, 100101 or 1, 101010 slt 10, 000100 sllv 9.
- 100011 lw: rfwe=1, mtorf=1, dst=rt, alu_in_sel=1, sel 2.
- 101011 sw: dmwe=1, alu_in_sel=1, sel 2.
- 000100 beq: branch=1, sel 3.
- 001000 addi: rfwe=1, dst=rt, alu_in_sel=1, sel 2.
- 000010 j: jump=1, sel 0.
REQ-009 SHALL decode R-type func 000000 as NOP: all enables 0, illegal=0.
REQ-010 SHALL, for any other op or R-type func, assert illegal=1 (when id_valid=1) and decode to a bubble (all enables 0, sel 0).
REQ-011 SHALL zero-extend ALU select codes to ALU_SEL_W.
REQ-012 SHALL define a bubble as valid=0, all enables 0, dst 0, sel 0.
REQ-013 SHALL force rfwe to 0 whenever dst==0.
REQ-014 SHALL assert hazard_stall combinationally when all hold: id_valid=1, ex_valid=1, ex_mtorf=1, ex_dst!=0, and (ex_dst==rs or (ex_dst==rt and op in {R-type, sw, beq})).
REQ-015 SHALL update pipe registers each rising clk with priority stall_ext > flush > hazard_stall > normal:
- stall_ext: all stages hold.
- flush: ID/EX loads a bubble; EX/MEM and MEM/WB advance.
- hazard_stall: ID/EX loads a bubble; later stages advance.
- normal: ID/EX loads decode (bubble if id_valid=0 or illegal); later stages advance.
REQ-016 SHALL keep every output within one clk of the stage register driving it: EX outputs 1 cycle, MEM 2, WB 3 after ID capture.
REQ-017 SHALL keep hazard_stall and illegal forced to 0 while stall_ext=1.
REQ-018 SHALL increment stall_cnt on each clk with hazard_stall=1, saturating at 2^CNT_W-1.

Reset
REQ-019 SHALL, on rst_n low, immediately (no clk) set all stages to bubble and stall_cnt to 0; hazard_stall=0 as a result.
REQ-020 SHALL, on reset mid-operation, discard all in-flight instructions; first capture is on the first clk edge after rst_n rises.

Verification
REQ-021 SHALL check: reset, then add (op 0, func 100000, rd 3) -> ex_alu_sel=2, ex_rfwe=1, ex_dst=3 at cycle 1; wb_rfwe=1, wb_dst=3 at cycle 3.
REQ-022 SHALL check: lw rt=5, then add rs=5 -> hazard_stall=1 for one cycle; bubble in EX; add issues next; stall_cnt=1.
REQ-023 SHALL check: flush=1 with beq in ID -> ex_valid=0 next cycle, while the older MEM/WB contents advance unchanged.
REQ-024 SHALL check: stall_ext=1 for 3 cycles with sw in EX -> all stage outputs frozen; mem_dmwe=1 one cycle after release.
REQ-025 SHALL check: op 111111 -> illegal=1, bubble enters EX; R-type rd=0 -> ex_rfwe=0.
REQ-026 SHALL check: CNT_W=2 with 5 hazard cycles -> stall_cnt saturates at 3; rst_n low mid-pipe -> all valid=0 without clk.

Source files
------------

// File: rtl/pipe_control_unit.sv
// Pipeline control for a 5-stage MIPS-style core: decodes the ID instruction, detects
// load-use hazards, and carries control bits through the EX, MEM and WB stage registers.
module pipe_control_unit #(
    parameter int ALU_SEL_W = 4,
    parameter int REG_W     = 5,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [5:0]           i_op,
    input  logic [5:0]           i_func,
    input  logic [REG_W-1:0]     i_rs,
    input  logic [REG_W-1:0]     i_rt,
    input  logic [REG_W-1:0]     i_rd,
    input  logic                 i_id_valid,
    input  logic                 i_stall_ext,
    input  logic                 i_flush,
    output logic                 o_hazard_stall,
    output logic                 o_illegal,
    output logic                 o_ex_valid,
    output logic                 o_ex_rfwe,
    output logic                 o_ex_mtorf,
    output logic [REG_W-1:0]     o_ex_dst,
    output logic [ALU_SEL_W-1:0] o_ex_alu_sel,
    output logic                 o_ex_alu_in_sel,
    output logic                 o_ex_branch,
    output logic                 o_ex_jump,
    output logic                 o_mem_valid,
    output logic                 o_mem_rfwe,
    output logic                 o_mem_mtorf,
    output logic [REG_W-1:0]     o_mem_dst,
    output logic                 o_mem_dmwe,
    output logic                 o_wb_valid,
    output logic                 o_wb_rfwe,
    output logic                 o_wb_mtorf,
    output logic [REG_W-1:0]     o_wb_dst,
    output logic [CNT_W-1:0]     o_stall_cnt
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_NOP  = 6'b000000;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SLLV = 6'b000100;

    localparam logic [ALU_SEL_W-1:0] SEL_AND  = ALU_SEL_W'(0);
    localparam logic [ALU_SEL_W-1:0] SEL_OR   = ALU_SEL_W'(1);
    localparam logic [ALU_SEL_W-1:0] SEL_ADD  = ALU_SEL_W'(2);
    localparam logic [ALU_SEL_W-1:0] SEL_SUB  = ALU_SEL_W'(3);
    localparam logic [ALU_SEL_W-1:0] SEL_SLLV = ALU_SEL_W'(9);
    localparam logic [ALU_SEL_W-1:0] SEL_SLT  = ALU_SEL_W'(10);

    typedef struct packed {
        logic                 valid;
        logic                 rfwe;
        logic                 mtorf;
        logic [REG_W-1:0]     dst;
        logic [ALU_SEL_W-1:0] alu_sel;
        logic                 alu_in_sel;
        logic                 branch;
        logic                 jump;
        logic                 dmwe;
    } ctrl_t;

    ctrl_t            w_dec;
    logic             w_dec_illegal;
    logic             w_uses_rt;
    logic             w_hazard;
    ctrl_t            r_ex;
    logic             r_mem_valid;
    logic             r_mem_rfwe;
    logic             r_mem_mtorf;
    logic [REG_W-1:0] r_mem_dst;
    logic             r_mem_dmwe;
    logic             r_wb_valid;
    logic             r_wb_rfwe;
    logic             r_wb_mtorf;
    logic [REG_W-1:0] r_wb_dst;
    logic [CNT_W-1:0] r_stall_cnt;

    always_comb begin
        w_dec         = '0;
        w_dec_illegal = 1'b0;
        case (i_op)
            OP_RTYPE: begin
                w_dec.valid = 1'b1;
                case (i_func)
                    F_ADD:   w_dec.alu_sel = SEL_ADD;
                    F_SUB:   w_dec.alu_sel = SEL_SUB;
                    F_AND:   w_dec.alu_sel = SEL_AND;
                    F_OR:    w_dec.alu_sel = SEL_OR;
                    F_SLT:   w_dec.alu_sel = SEL_SLT;
                    F_SLLV:  w_dec.alu_sel = SEL_SLLV;
                    F_NOP:   w_dec.alu_sel = SEL_AND;
                    default: w_dec_illegal = 1'b1;
                endcase
                if (i_func != F_NOP) begin
                    w_dec.rfwe = 1'b1;
                    w_dec.dst  = i_rd;
                end
            end
            OP_LW: begin
                w_dec.valid      = 1'b1;
                w_dec.rfwe       = 1'b1;
                w_dec.mtorf      = 1'b1;
                w_dec.dst        = i_rt;
                w_dec.alu_in_sel = 1'b1;
                w_dec.alu_sel    = SEL_ADD;
            end
            OP_SW: begin
                w_dec.valid      = 1'b1;
                w_dec.dmwe       = 1'b1;
                w_dec.alu_in_sel = 1'b1;
                w_dec.alu_sel    = SEL_ADD;
            end
            OP_BEQ: begin
                w_dec.valid   = 1'b1;
                w_dec.branch  = 1'b1;
                w_dec.alu_sel = SEL_SUB;
            end
            OP_ADDI: begin
                w_dec.valid      = 1'b1;
                w_dec.rfwe       = 1'b1;
                w_dec.dst        = i_rt;
                w_dec.alu_in_sel = 1'b1;
                w_dec.alu_sel    = SEL_ADD;
            end
            OP_J: begin
                w_dec.valid = 1'b1;
                w_dec.jump  = 1'b1;
            end
            default: w_dec_illegal = 1'b1;
        endcase
        // Register 0 is hardwired; a write to it must never be signalled.
        if (w_dec.dst == '0) w_dec.rfwe = 1'b0;
        if (w_dec_illegal || !i_id_valid) w_dec = '0;
    end

    assign w_uses_rt = (i_op == OP_RTYPE) || (i_op == OP_SW) || (i_op == OP_BEQ);

    // Load-use: the loaded value is not available until MEM, so hold ID one cycle.
    assign w_hazard = !i_stall_ext && i_id_valid && r_ex.valid && r_ex.mtorf &&
                      (r_ex.dst != '0) &&
                      ((r_ex.dst == i_rs) || ((r_ex.dst == i_rt) && w_uses_rt));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex        <= '0;
            r_mem_valid <= 1'b0;
            r_mem_rfwe  <= 1'b0;
            r_mem_mtorf <= 1'b0;
            r_mem_dst   <= '0;
            r_mem_dmwe  <= 1'b0;
            r_wb_valid  <= 1'b0;
            r_wb_rfwe   <= 1'b0;
            r_wb_mtorf  <= 1'b0;
            r_wb_dst    <= '0;
            r_stall_cnt <= '0;
        end else if (!i_stall_ext) begin
            r_ex        <= (i_flush || w_hazard) ? '0 : w_dec;
            r_mem_valid <= r_ex.valid;
            r_mem_rfwe  <= r_ex.rfwe;
            r_mem_mtorf <= r_ex.mtorf;
            r_mem_dst   <= r_ex.dst;
            r_mem_dmwe  <= r_ex.dmwe;
            r_wb_valid  <= r_mem_valid;
            r_wb_rfwe   <= r_mem_rfwe;
            r_wb_mtorf  <= r_mem_mtorf;
            r_wb_dst    <= r_mem_dst;
            if (w_hazard && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign o_hazard_stall  = w_hazard;
    assign o_illegal       = i_id_valid && w_dec_illegal && !i_stall_ext;
    assign o_ex_valid      = r_ex.valid;
    assign o_ex_rfwe       = r_ex.rfwe;
    assign o_ex_mtorf      = r_ex.mtorf;
    assign o_ex_dst        = r_ex.dst;
    assign o_ex_alu_sel    = r_ex.alu_sel;
    assign o_ex_alu_in_sel = r_ex.alu_in_sel;
    assign o_ex_branch     = r_ex.branch;
    assign o_ex_jump       = r_ex.jump;
    assign o_mem_valid     = r_mem_valid;
    assign o_mem_rfwe      = r_mem_rfwe;
    assign o_mem_mtorf     = r_mem_mtorf;
    assign o_mem_dst       = r_mem_dst;
    assign o_mem_dmwe      = r_mem_dmwe;
    assign o_wb_valid      = r_wb_valid;
    assign o_wb_rfwe       = r_wb_rfwe;
    assign o_wb_mtorf      = r_wb_mtorf;
    assign o_wb_dst        = r_wb_dst;
    assign o_stall_cnt     = r_stall_cnt;

endmodule
